// File: rtl/i2s_pkg.sv
// i2s_pkg
// Shared types and helpers for the I2S transmitter.
//   frame_t       : packed frame, wide enough for the largest supported slot.
//                   Frames are right-aligned: bit b of an F-bit frame sits at
//                   position F-1-b, so the first transmitted bit is the MSB.
//   lrclk_for_bit : word-select level during frame bit b (one-bit I2S lead).
//   pack_frame    : builds {left, pad, right, pad} for the given widths.
package i2s_pkg;

   localparam int MAX_SLOT  = 32;
   localparam int MAX_FRAME = 2 * MAX_SLOT;

   typedef logic [MAX_FRAME-1:0] frame_t;

   // LRCLK goes high one bit before the right slot and drops one bit before
   // the next left slot.
   function automatic logic lrclk_for_bit(input int b, input int slot_w);
      return (b >= slot_w - 1) && (b <= 2 * slot_w - 2);
   endfunction

   // Samples arrive right-aligned in MAX_SLOT-wide vectors; each one is
   // placed MSB-first at the top of its slot and the rest of the slot is 0.
   function automatic frame_t pack_frame(input logic [MAX_SLOT-1:0] l,
                                         input logic [MAX_SLOT-1:0] r,
                                         input int sample_w,
                                         input int slot_w);
      frame_t f;
      f = '0;
      for (int i = 0; i < sample_w; i++) begin
         f[2 * slot_w - 1 - i] = l[sample_w - 1 - i];
         f[slot_w - 1 - i]     = r[sample_w - 1 - i];
      end
      return f;
   endfunction

endpackage

// File: rtl/i2s_tx_bclk_gen.sv
// i2s_bclk_gen
// Bit-clock generator: a 0..CLK_DIV-1 divider that toggles bclk on wrap.
//   clk, reset : system clock, synchronous active-high reset
//   bclk       : registered bit clock (0 after reset)
//   rise       : one-clk strobe on the cycle whose edge drives bclk 0->1
//   fall       : one-clk strobe on the cycle whose edge drives bclk 1->0
// Strobes are combinational from registers so the consumer can update its
// own registers on the same edge that bclk falls.
module i2s_bclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic bclk,
   output logic rise,
   output logic fall
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_cnt_reg;
   logic          bclk_reg;
   logic          wrap;

   assign wrap = (div_cnt_reg == DW'(CLK_DIV - 1));
   assign rise = wrap & ~bclk_reg;
   assign fall = wrap & bclk_reg;
   assign bclk = bclk_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_reg <= '0;
         bclk_reg    <= 1'b0;
      end else if (wrap) begin
         div_cnt_reg <= '0;
         bclk_reg    <= ~bclk_reg;
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx
// I2S serial audio transmitter with a one-sample holding register in front
// of the frame shift register.
//   clk, reset         : system clock, synchronous active-high reset
//   sample_l, sample_r : signed stereo sample, accepted on valid & ready
//   sample_valid       : producer offers a sample
//   sample_ready       : holding register empty (registered)
//   i2s_bclk           : bit clock, period 2*CLK_DIV clk
//   i2s_lrclk          : word select, 0 = left, 1 = right, one-bit lead
//   i2s_sdata          : serial data, MSB first, changes on BCLK fall
//   underrun           : one-clk pulse when a frame starts with holding empty
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SLOT_WIDTH   = 16,
   parameter int CLK_DIV      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] sample_l,
   input  logic [SAMPLE_WIDTH-1:0] sample_r,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic                    i2s_bclk,
   output logic                    i2s_lrclk,
   output logic                    i2s_sdata,
   output logic                    underrun
);

   localparam int F  = 2 * SLOT_WIDTH;
   localparam int BW = $clog2(F);

   logic bclk_fall;
   logic bclk_rise_unused;

   i2s_bclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_bclk_gen (
      .clk   (clk),
      .reset (reset),
      .bclk  (i2s_bclk),
      .rise  (bclk_rise_unused),
      .fall  (bclk_fall)
   );

   logic [BW-1:0]           bit_cnt_reg;
   logic [F-1:0]            shift_reg;
   logic [SAMPLE_WIDTH-1:0] hold_l_reg;
   logic [SAMPLE_WIDTH-1:0] hold_r_reg;
   logic                    hold_full_reg;
   logic                    hold_full_next;
   logic                    ready_reg;
   logic                    lrclk_reg;
   logic                    sdata_reg;
   logic                    underrun_reg;
   logic                    frame_end;
   logic                    load_now;
   logic                    accept;

   assign frame_end = (bit_cnt_reg == BW'(F - 1));
   assign load_now  = bclk_fall & frame_end;
   assign accept    = sample_valid & ready_reg;

   // A load only empties a full holding register; ready is low while full,
   // so a load-and-accept on the same edge can only happen when holding was
   // empty. In that case the load transmits zeros and the new sample stays.
   always_comb begin
      hold_full_next = hold_full_reg;
      if (load_now && hold_full_reg) begin
         hold_full_next = 1'b0;
      end else if (accept) begin
         hold_full_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         hold_l_reg    <= '0;
         hold_r_reg    <= '0;
         hold_full_reg <= 1'b0;
         ready_reg     <= 1'b1;
         lrclk_reg     <= 1'b0;
         sdata_reg     <= 1'b0;
         underrun_reg  <= 1'b0;
      end else begin
         underrun_reg  <= 1'b0;
         hold_full_reg <= hold_full_next;
         ready_reg     <= ~hold_full_next;

         if (accept) begin
            hold_l_reg <= sample_l;
            hold_r_reg <= sample_r;
         end

         if (bclk_fall) begin
            if (frame_end) begin
               bit_cnt_reg <= '0;
               lrclk_reg   <= lrclk_for_bit(0, SLOT_WIDTH);
               if (hold_full_reg) begin
                  shift_reg <= F'(pack_frame(MAX_SLOT'(hold_l_reg),
                                             MAX_SLOT'(hold_r_reg),
                                             SAMPLE_WIDTH, SLOT_WIDTH));
                  // First bit of the new frame is the left MSB.
                  sdata_reg <= hold_l_reg[SAMPLE_WIDTH-1];
               end else begin
                  shift_reg    <= '0;
                  sdata_reg    <= 1'b0;
                  underrun_reg <= 1'b1;
               end
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 1'b1;
               // shift_reg[F-1] is always the bit currently on the wire.
               shift_reg   <= shift_reg << 1;
               sdata_reg   <= shift_reg[F-2];
               lrclk_reg   <= lrclk_for_bit(int'(bit_cnt_reg) + 1, SLOT_WIDTH);
            end
         end
      end
   end

   assign sample_ready = ready_reg;
   assign i2s_lrclk    = lrclk_reg;
   assign i2s_sdata    = sdata_reg;
   assign underrun     = underrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;

   // DUT A: defaults (16-bit sample, 16-bit slot, CLK_DIV 4)
   logic [15:0] a_l = '0, a_r = '0;
   logic        a_valid = 1'b0;
   logic        a_ready, a_bclk, a_lr, a_sd, a_ur;

   // DUT B: 16-bit sample in 24-bit slot, CLK_DIV 1
   logic [15:0] b_l = '0, b_r = '0;
   logic        b_valid = 1'b0;
   logic        b_ready, b_bclk, b_lr, b_sd, b_ur;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit stream   = 1'b0;

   logic [63:0] d, lr;
   bit          bad;

   i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CLK_DIV(4)) dut_a (
      .clk(clk), .reset(reset),
      .sample_l(a_l), .sample_r(a_r), .sample_valid(a_valid),
      .sample_ready(a_ready), .i2s_bclk(a_bclk), .i2s_lrclk(a_lr),
      .i2s_sdata(a_sd), .underrun(a_ur)
   );

   i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(24), .CLK_DIV(1)) dut_b (
      .clk(clk), .reset(reset),
      .sample_l(b_l), .sample_r(b_r), .sample_valid(b_valid),
      .sample_ready(b_ready), .i2s_bclk(b_bclk), .i2s_lrclk(b_lr),
      .i2s_sdata(b_sd), .underrun(b_ur)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are observed 1 time unit after the rising edge.
   // In streaming mode the producer moves to the next sample once accepted.
   task automatic tick();
      logic acc;
      acc = a_valid & a_ready & ~reset;
      @(posedge clk);
      #1;
      cyc++;
      if (acc && stream) begin
         a_l++;
         a_r++;
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset(input string tag);
      reset   = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      check({tag, "_a"}, {a_bclk, a_lr, a_sd, a_ur, a_ready}, 5'b00001);
      check({tag, "_b"}, {b_bclk, b_lr, b_sd, b_ur, b_ready}, 5'b00001);
      reset = 1'b0;
      cyc   = 0;
   endtask

   // Collects one frame starting at the current cycle (just after a load).
   task automatic capture(input bit sel, input int nbits, input int half,
                          output logic [63:0] dat, output logic [63:0] wsel);
      dat  = '0;
      wsel = '0;
      for (int b = 0; b < nbits; b++) begin
         dat[nbits-1-b]  = sel ? b_sd : a_sd;
         wsel[nbits-1-b] = sel ? b_lr : a_lr;
         repeat (2 * half) tick();
      end
   endtask

   initial begin
      // Idle after reset: BCLK timing, silence, periodic underrun
      do_reset("reset_vals");
      run_to(4);   check("bclk_c4", a_bclk, 1'b1);
      run_to(7);   check("bclk_c7", a_bclk, 1'b1);
      run_to(8);   check("bclk_c8", a_bclk, 1'b0);
      bad = 1'b0;
      while (cyc < 255) begin
         tick();
         if (a_sd !== 1'b0 || a_ur !== 1'b0) bad = 1'b1;
      end
      check("idle_quiet", bad, 1'b0);
      run_to(256); check("ur_c256", a_ur, 1'b1);
      check("idle_sd_c256", a_sd, 1'b0);
      tick();      check("ur_c257", a_ur, 1'b0);
      run_to(511); check("ur_c511", a_ur, 1'b0);
      run_to(512); check("ur_c512", a_ur, 1'b1);

      // Single write right after reset, sent in the second frame
      do_reset("reset_b");
      a_l = 16'h8001; a_r = 16'h7FFE; a_valid = 1'b1;
      tick();
      check("ready_after_write", a_ready, 1'b0);
      a_valid = 1'b0;
      run_to(256);
      check("single_ur_c256", a_ur, 1'b0);
      check("single_ready_c256", a_ready, 1'b1);
      capture(1'b0, 32, 4, d, lr);
      check("single_frame", d, 64'h8001_7FFE);
      check("single_lrclk", lr, 64'h0001_FFFE);
      check("single_ur_c512", a_ur, 1'b1);

      // Back-to-back streaming with valid held high
      do_reset("reset_c");
      a_l = 16'hA5A5; a_r = 16'h5A5A; stream = 1'b1; a_valid = 1'b1;
      run_to(256);
      check("stream_ur_c256", a_ur, 1'b0);
      check("stream_ready_c256", a_ready, 1'b1);
      capture(1'b0, 32, 4, d, lr);
      check("stream_frame0", d, 64'hA5A5_5A5A);
      check("stream_ur_c512", a_ur, 1'b0);
      check("stream_ready_c512", a_ready, 1'b1);
      capture(1'b0, 32, 4, d, lr);
      check("stream_frame1", d, 64'hA5A6_5A5B);
      check("stream_ur_c768", a_ur, 1'b0);
      stream = 1'b0; a_valid = 1'b0;

      // Write on the exact frame-load cycle
      do_reset("reset_d");
      run_to(255);
      a_l = 16'h1234; a_r = 16'hABCD; a_valid = 1'b1;
      tick();
      check("race_ur_c256", a_ur, 1'b1);
      check("race_ready_c256", a_ready, 1'b0);
      a_valid = 1'b0;
      capture(1'b0, 32, 4, d, lr);
      check("race_mute_frame", d, 64'h0);
      check("race_ur_c512", a_ur, 1'b0);
      check("race_ready_c512", a_ready, 1'b1);
      capture(1'b0, 32, 4, d, lr);
      check("race_next_frame", d, 64'h1234_ABCD);

      // Reset mid-frame with holding full discards the sample
      do_reset("reset_e");
      a_l = 16'hFFFF; a_r = 16'hFFFF; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      run_to(100);
      do_reset("reset_mid");
      run_to(256);
      check("mid_ur_c256", a_ur, 1'b1);
      capture(1'b0, 32, 4, d, lr);
      check("mid_frame_zero", d, 64'h0);
      check("mid_ur_c512", a_ur, 1'b1);

      // 24-bit slots, 16-bit samples, CLK_DIV 1: frame = 48 BCLK = 96 clk
      do_reset("reset_f");
      b_l = 16'hFFFF; b_r = 16'h0001; b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      run_to(96);
      check("wide_ur_c96", b_ur, 1'b0);
      capture(1'b1, 48, 1, d, lr);
      check("wide_frame", d, 64'hFFFF00_000100);
      check("wide_lrclk", lr, 64'h000001_FFFFFE);
      check("wide_ur_c192", b_ur, 1'b1);
      tick();
      check("wide_ur_c193", b_ur, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial audio transmitter at the output end of the sample path. Accepts one parallel signed stereo sample per frame through a valid/ready handshake. Serialises it MSB-first as standard I2S (one-bit LRCLK lead) toward an external DAC. Double-buffered: one holding register plus one frame shift register, so the producer has a full frame period to deliver the next sample.

## Interface
- `SAMPLE_WIDTH`, default 16: bits per channel sample.
- `SLOT_WIDTH`, default 16: BCLK periods per channel slot; must be ≥ `SAMPLE_WIDTH`; bits beyond the sample are padded with 0.
- `CLK_DIV`, default 4: `clk` cycles per BCLK half-period; must be ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `sample_l`  in  `SAMPLE_WIDTH`  left sample, signed two's complement.
- `sample_r`  in  `SAMPLE_WIDTH`  right sample, signed.
- `sample_valid`  in  1  producer offers `sample_l`/`sample_r`.
- `sample_ready`  out  1  holding register empty; transfer occurs when valid & ready.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrclk`  out  1  word select; 0 = left, 1 = right.
- `i2s_sdata`  out  1  serial data.
- `underrun`  out  1  one-`clk` pulse when a frame starts with the holding register empty.

## Operation
- Let S = `SLOT_WIDTH` and F = 2·S (bits per frame). Frame bit index b runs 0..F-1.
- Frame layout: b = 0..S-1 is the left slot, b = S..F-1 is the right slot. Each slot carries the sample MSB first, then zero padding.
- `i2s_lrclk` during bit b is 1 for b ∈ [S-1, F-2] and 0 otherwise. This is the one-bit I2S lead.
- Divider: a counter 0..`CLK_DIV`-1. On wrap it toggles `i2s_bclk`.
  - A 1→0 toggle is a fall strobe.
  - On each fall strobe, b advances, then `i2s_sdata` and `i2s_lrclk` update.
  - Outputs are stable across the rising edge.
- Frame load happens on the fall strobe that ends b = F-1:
  - If holding is full: shift register ← {sample_l, pad, sample_r, pad}, holding becomes empty.
  - If holding is empty: shift register ← all zeros (mute), and `underrun` = 1 for that one cycle.
- Handshake:
  - `sample_ready` = ~holding_full, registered.
  - When valid & ready, holding captures the data on that edge, and `sample_ready` is 0 from the next cycle.
  - `sample_valid` while not ready is ignored; the data is held by the producer.
- Simultaneous write and frame load (same cycle, holding was empty):
  - The load sees empty, transmits zeros, and pulses `underrun`.
  - The written sample stays in holding for the next frame.
- Reset values:
  - `i2s_bclk` = 0, `i2s_lrclk` = 0, `i2s_sdata` = 0, `underrun` = 0, `sample_ready` = 1.
  - Divider = 0, b = 0, shift register = 0, holding empty.
- The reset state represents bit 0 of a zero frame already in progress. The first accepted sample goes out in the second frame, and no `underrun` is flagged for the post-reset frame.
- Reset mid-frame aborts the frame immediately and discards the holding contents.

## Timing
- BCLK period = 2·`CLK_DIV` clk. Frame = F·2·`CLK_DIV` clk (defaults: 8 and 256).
- First fall strobe after reset: cycle 2·`CLK_DIV`. First frame load: cycle F·2·`CLK_DIV` after reset deassertion.
- Latency from handshake to the MSB appearing on `i2s_sdata`: at most one frame plus one bit period.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `i2s_pkg`:
  - `frame_t` typedef (F-bit packed frame).
  - Functions `lrclk_for_bit(b)` and `pack_frame(l, r)`.
- One sub-module `i2s_bclk_gen`: divider, `i2s_bclk` register, rise/fall strobes.
- The top holds the bit counter, shift register, holding register and handshake.

## Test plan
- Reset, no input, defaults: `i2s_sdata` stays 0; first `underrun` pulse at cycle 256, then every 256 cycles; `i2s_bclk` period 8.
- Write L=16'h8001, R=16'h7FFE once, immediately after reset: the second frame shows left bits 1000…0001 and right bits 0111…1110. `i2s_lrclk` rises exactly one BCLK before the right MSB and falls one BCLK before the left MSB.
- Back-to-back streaming with valid held high (L=16'hA5A5, R=16'h5A5A incrementing): every frame is correct and no `underrun`. `sample_ready` reasserts within one cycle of each frame load.
- `SLOT_WIDTH`=24, `SAMPLE_WIDTH`=16, L=16'hFFFF: 16 ones, then 8 zeros in the left slot; frame = 48 BCLK.
- Write issued on the exact frame-load cycle: that frame is zero with `underrun`=1, and the sample appears in the following frame.
- Assert `reset` mid-frame with holding full: outputs return to reset values next cycle; the held sample is never transmitted.
